// File: rtl/axis_src_pkg.sv
// Shared state encoding and default widths for axis_packet_source.
package axis_src_pkg;

  localparam int DEF_TDATA_WIDTH = 32;
  localparam int DEF_LEN_WIDTH   = 16;
  localparam int DEF_GAP_WIDTH   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/axis_packet_source.sv
// AXI-Stream packet source: one packet of incrementing data per accepted start,
// optional idle gap after each non-last beat.
// Ports: m00_axis_* AXIS master; start/pkt_len/seed/gap request; busy/done/
// pkt_count/state status.
module axis_packet_source
  import axis_src_pkg::*;
#(
  parameter int TDATA_WIDTH            = DEF_TDATA_WIDTH,
  parameter int C_M00_AXIS_TDATA_WIDTH = TDATA_WIDTH,
  parameter int LEN_WIDTH              = DEF_LEN_WIDTH,
  parameter int GAP_WIDTH              = DEF_GAP_WIDTH,
  parameter int CNT_WIDTH              = 16
) (
  input  logic                                  m00_axis_aclk,
  input  logic                                  m00_axis_aresetn,
  input  logic                                  start,
  input  logic [LEN_WIDTH-1:0]                  pkt_len,
  input  logic [TDATA_WIDTH-1:0]                seed,
  input  logic [GAP_WIDTH-1:0]                  gap,
  output logic                                  m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                                  m00_axis_tlast,
  input  logic                                  m00_axis_tready,
  output logic                                  busy,
  output logic                                  done,
  output logic [CNT_WIDTH-1:0]                  pkt_count,
  output logic [1:0]                            state
);

  localparam logic [C_M00_AXIS_TDATA_WIDTH-1:0] DATA_ONE = C_M00_AXIS_TDATA_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]              LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [GAP_WIDTH-1:0]              GAP_ONE  = GAP_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]              CNT_ONE  = CNT_WIDTH'(1);

  state_t                 st;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   beat_cnt;
  logic [GAP_WIDTH-1:0]   gap_q;
  logic [GAP_WIDTH-1:0]   gap_cnt;

  assign state          = st;
  assign m00_axis_tstrb = '1;

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      st              <= IDLE;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tlast  <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pkt_count       <= '0;
      len_q           <= '0;
      gap_q           <= '0;
      beat_cnt        <= '0;
      gap_cnt         <= '0;
    end else begin
      done <= 1'b0;
      unique case (st)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (pkt_len != '0) begin
              len_q           <= pkt_len;
              gap_q           <= gap;
              m00_axis_tdata  <= seed;
              beat_cnt        <= LEN_ONE;
              m00_axis_tlast  <= (pkt_len == LEN_ONE);
              m00_axis_tvalid <= 1'b1;
              st              <= SEND;
            end else begin
              done <= 1'b1;
              st   <= DONE;
            end
          end
        end
        SEND: begin
          // tvalid is always high here, so tready alone marks a transfer
          if (m00_axis_tready) begin
            if (m00_axis_tlast) begin
              m00_axis_tvalid <= 1'b0;
              m00_axis_tlast  <= 1'b0;
              pkt_count       <= pkt_count + CNT_ONE;
              done            <= 1'b1;
              st              <= DONE;
            end else begin
              m00_axis_tdata <= m00_axis_tdata + DATA_ONE;
              beat_cnt       <= beat_cnt + LEN_ONE;
              if (gap_q == '0) begin
                m00_axis_tlast <= (beat_cnt + LEN_ONE == len_q);
              end else begin
                m00_axis_tvalid <= 1'b0;
                gap_cnt         <= gap_q;
                st              <= GAP;
              end
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - GAP_ONE;
          if (gap_cnt == GAP_ONE) begin
            // beat_cnt was already advanced on the transfer that entered GAP
            m00_axis_tvalid <= 1'b1;
            m00_axis_tlast  <= (beat_cnt == len_q);
            st              <= SEND;
          end
        end
        DONE: begin
          busy <= 1'b0;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_packet_source.sv
module tb_axis_packet_source;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pkt_len = '0;
  logic [31:0] seed = '0;
  logic [7:0]  gap = '0;
  logic        tready = 1'b0;
  logic        tvalid;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast;
  logic        busy;
  logic        done;
  logic [15:0] pkt_count;
  logic [1:0]  state;

  axis_packet_source #(
    .TDATA_WIDTH(32),
    .C_M00_AXIS_TDATA_WIDTH(32),
    .LEN_WIDTH(16),
    .GAP_WIDTH(8),
    .CNT_WIDTH(16)
  ) dut (
    .m00_axis_aclk(clk),
    .m00_axis_aresetn(rst_n),
    .start(start),
    .pkt_len(pkt_len),
    .seed(seed),
    .gap(gap),
    .m00_axis_tvalid(tvalid),
    .m00_axis_tdata(tdata),
    .m00_axis_tstrb(tstrb),
    .m00_axis_tlast(tlast),
    .m00_axis_tready(tready),
    .busy(busy),
    .done(done),
    .pkt_count(pkt_count),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    int          len;
    logic [31:0] sd;
    int          gp;
    int          exp_ticks;
    int          exp_beats;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    int          exp_cnt;
  } vec_t;

  beat_t q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    model_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transfer monitor and AXIS hold rule, sampled mid-cycle.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {tvalid, tlast, tdata}, {1'b1, prev_last, prev_data});
      if (tvalid && tready)
        q.push_back({tdata, tlast});
      prev_stall <= tvalid && !tready;
      prev_data  <= tdata;
      prev_last  <= tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_ready(input int prob);
    return ($urandom_range(0, 99) < prob);
  endfunction

  // Expected stream: beat i carries seed+i (mod 2^32), tlast only on beat len-1.
  task automatic check_stream(input string tag, input int len, input logic [31:0] sd);
    int          nerr = 0;
    logic [31:0] expd;
    check({tag, "_beats"}, q.size(), len);
    for (int i = 0; i < q.size() && i < len; i++) begin
      expd = sd + 32'(i);
      if (q[i].data !== expd || q[i].last !== (i == len - 1)) begin
        if (nerr == 0)
          $display("  %s beat %0d: data %0h want %0h, last %0b", tag, i, q[i].data, expd, q[i].last);
        nerr++;
      end
    end
    check({tag, "_stream"}, nerr, 0);
  endtask

  task automatic finish_pkt(input string tag, input int len, input logic [31:0] sd);
    check_stream(tag, len, sd);
    if (len != 0) model_cnt = (model_cnt + 1) % 65536;
    check({tag, "_pkt_count"}, pkt_count, model_cnt);
  endtask

  // Issue one start and run until done, tready high with probability prob%.
  task automatic run_pkt(input int len, input logic [31:0] sd, input int gp, input int prob,
                         output int ticks);
    q.delete();
    pkt_len = 16'(len);
    seed    = sd;
    gap     = 8'(gp);
    start   = 1'b1;
    tready  = rnd_ready(prob);
    tick();
    ticks = 1;
    start   = 1'b0;
    check("busy_after_start", busy, 1);
    pkt_len = 16'($urandom);
    seed    = $urandom;
    gap     = 8'($urandom);
    while (!done && ticks < 70000) begin
      tready = rnd_ready(prob);
      tick();
      ticks++;
    end
    check("done_seen", done, 1);
    tready = rnd_ready(prob);
    tick();
    check("done_one_cycle", done, 0);
    check("idle_after_done", {busy, state}, 3'b000);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_done"}, done, 1);
    tick();
  endtask

  vec_t tbl[6];

  initial begin
    int          t;
    logic [6:0]  wv;
    int          len;
    int          gp;
    logic [31:0] sd;

    tbl[0] = '{4, 32'h10,        0, 5,  4, 32'h10,        32'h13,        1};
    tbl[1] = '{3, 32'h0,         2, 8,  3, 32'h0,         32'h2,         2};
    tbl[2] = '{1, 32'hFFFF_FFFF, 0, 2,  1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3};
    tbl[3] = '{2, 32'hFFFF_FFFF, 0, 3,  2, 32'hFFFF_FFFF, 32'h0,         4};
    tbl[4] = '{0, 32'h5,         3, 1,  0, 32'h0,         32'h0,         4};
    tbl[5] = '{5, 32'h100,       1, 10, 5, 32'h100,       32'h104,       5};

    // Reset state
    #3;
    check("reset_outputs", {tvalid, tlast, busy, done, state}, 6'b0);
    check("reset_tdata", tdata, 0);
    check("reset_pkt_count", pkt_count, 0);
    check("tstrb", tstrb, 4'hF);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Table-driven packets with tready held high
    foreach (tbl[k]) begin
      run_pkt(tbl[k].len, tbl[k].sd, tbl[k].gp, 100, t);
      check($sformatf("tbl%0d_ticks", k), t, tbl[k].exp_ticks);
      check($sformatf("tbl%0d_nbeats", k), q.size(), tbl[k].exp_beats);
      if (tbl[k].exp_beats > 0 && q.size() > 0) begin
        check($sformatf("tbl%0d_first", k), q[0].data, tbl[k].exp_first);
        check($sformatf("tbl%0d_last", k), q[q.size()-1].data, tbl[k].exp_last);
        check($sformatf("tbl%0d_tlast", k), q[q.size()-1].last, 1);
      end
      check($sformatf("tbl%0d_cnt", k), pkt_count, tbl[k].exp_cnt);
      finish_pkt($sformatf("tbl%0d", k), tbl[k].len, tbl[k].sd);
    end

    // Backpressure on beat 1
    q.delete();
    pkt_len = 16'd3; seed = 32'h0; gap = 8'd0; start = 1'b1; tready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_stall", {tvalid, tdata}, {1'b1, 32'h1});
    end
    tready = 1'b1;
    wait_done("bp");
    finish_pkt("bp", 3, 32'h0);

    // Gap waveform on tvalid
    q.delete();
    pkt_len = 16'd3; seed = 32'h0; gap = 8'd2; start = 1'b1; tready = 1'b1;
    wv = '0;
    for (int i = 0; i < 7; i++) begin
      tick();
      start = 1'b0;
      wv = {wv[5:0], tvalid};
    end
    check("gap_wave", wv, 7'b1001001);
    wait_done("gap");
    finish_pkt("gap", 3, 32'h0);

    // start during SEND and during DONE is ignored
    q.delete();
    pkt_len = 16'd5; seed = 32'h20; gap = 8'd0; start = 1'b1; tready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    while (!done && t < 50) begin
      tick();
      t++;
    end
    check("ign_done", done, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("ign_idle", {tvalid, busy, state}, 4'b0);
    finish_pkt("ign", 5, 32'h20);

    // Randomized packets against the model
    for (int i = 0; i < 40; i++) begin
      len = $urandom_range(0, 12);
      gp  = $urandom_range(0, 3);
      sd  = (i % 4 == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 5)) : $urandom;
      run_pkt(len, sd, gp, $urandom_range(30, 100), t);
      finish_pkt($sformatf("rnd%0d", i), len, sd);
    end

    // Maximum length packet
    run_pkt(65535, 32'hFFFF_0000, 0, 100, t);
    check("max_ticks", t, 65536);
    finish_pkt("max", 65535, 32'hFFFF_0000);

    // Asynchronous reset during beat 2 of 5
    q.delete();
    pkt_len = 16'd5; seed = 32'h40; gap = 8'd0; start = 1'b1; tready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("ar_mid_beat2", {tvalid, tdata}, {1'b1, 32'h41});
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_outputs", {tvalid, tlast, busy, done, state}, 6'b0);
    check("ar_pkt_count", pkt_count, 0);
    check("ar_tdata", tdata, 0);
    tick();
    tick();
    rst_n = 1'b1;
    model_cnt = 0;
    run_pkt(3, 32'h77, 1, 100, t);
    check("ar_fresh_ticks", t, 6);
    finish_pkt("ar_fresh", 3, 32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_packet_source.md
Name: axis_packet_source

Overview:
- AXI-Stream master-side traffic source: on a start pulse, emits one packet of pkt_len beats of incrementing data starting at seed, with tlast on the final beat.
- Honours downstream backpressure, and can insert idle gap cycles between beats.
- Drives stream-processing blocks (e.g. the stream shifter) in bring-up and test designs, and provides packet/done status for software or a bench.

Parameters:
- TDATA_WIDTH, 32, data width in bits; must be a multiple of 8.
- C_M00_AXIS_TDATA_WIDTH, TDATA_WIDTH, width of the M00_AXIS bus.
- LEN_WIDTH, 16, width of pkt_len and of the internal beat counter.
- GAP_WIDTH, 8, width of gap and of the internal gap counter.
- CNT_WIDTH, 16, width of pkt_count.

Ports:
- m00_axis_aclk  in  1  single clock for the whole block.
- m00_axis_aresetn  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to send one packet; sampled only in IDLE.
- pkt_len  in  LEN_WIDTH  beats per packet; latched at accepted start.
- seed  in  TDATA_WIDTH  data value of the first beat; latched at accepted start.
- gap  in  GAP_WIDTH  idle cycles inserted after each non-last transfer; latched at accepted start.
- m00_axis_tvalid  out  1  AXIS valid.
- m00_axis_tdata  out  TDATA_WIDTH  AXIS data.
- m00_axis_tstrb  out  TDATA_WIDTH/8  AXIS strobe; constant all ones.
- m00_axis_tlast  out  1  high on the final beat of a packet.
- m00_axis_tready  in  1  AXIS ready from the downstream slave.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last beat transfers.
- pkt_count  out  CNT_WIDTH  number of completed nonzero-length packets; wraps at 2^CNT_WIDTH.
- state  out  2  debug view of the FSM state.

Behaviour:
- Reset:
  - m00_axis_aresetn low forces state=IDLE immediately, without waiting for a clock edge.
  - tvalid, tlast, done, busy are 0; tdata, pkt_count and all internal counters are 0.
  - Reset mid-packet drops the packet; no tlast is issued for it.
- State encoding: IDLE=2'b00, SEND=2'b01, GAP=2'b10, DONE=2'b11. The state port equals the state register.
- All outputs are registered. No combinational path from tready to any output.
- A transfer is any cycle with tvalid and tready both high at the rising edge.
- IDLE:
  - On start=1 with pkt_len!=0: latch pkt_len/seed/gap, load tdata=seed, beat counter=1, tlast=(pkt_len==1), tvalid=1, go to SEND.
  - The first beat is therefore valid one cycle after start.
  - On start=1 with pkt_len==0: go to DONE, emit no beat, leave pkt_count unchanged.
- SEND:
  - tvalid=1. While tready=0, tdata and tlast are held stable (AXIS rule).
  - Transfer with tlast=1: tvalid<=0, tlast<=0, pkt_count<=pkt_count+1, go to DONE.
  - Transfer with tlast=0 and latched gap==0: stay in SEND with tvalid kept high.
    - tdata<=tdata+1, wrapping modulo 2^TDATA_WIDTH.
    - Beat counter increments; tlast<=(counter+1==pkt_len).
    - Back-to-back streaming gives one beat per cycle.
  - Transfer with tlast=0 and gap!=0: tvalid<=0, load gap counter=gap, go to GAP.
    - tdata advances to the next value immediately but is not valid.
- GAP:
  - Decrement the gap counter each cycle.
  - When it reaches 1: tvalid<=1, tlast<=(counter==pkt_len), go to SEND.
  - tvalid is low for exactly gap cycles.
- DONE:
  - done=1 for exactly this one cycle, then go to IDLE.
  - start in DONE is ignored.
- start in SEND/GAP is ignored.
- pkt_len, seed and gap may change while busy without effect.
- pkt_len = 2^LEN_WIDTH-1 must work: no counter overflow before tlast.

Decomposition:
- Package axis_src_pkg holds:
  - state encoding constants IDLE/SEND/GAP/DONE;
  - the default widths TDATA_WIDTH=32, LEN_WIDTH=16, GAP_WIDTH=8.
- The block is a single module with no sub-module. The FSM, beat counter and gap counter are small enough to stay flat.

Test Plan:
- Back-to-back streaming: reset, then start with pkt_len=4, seed=32'h10, gap=0, tready=1.
  - tdata 10,11,12,13 on 4 consecutive cycles starting 1 cycle after start.
  - tlast only with 13; done pulses the next cycle; pkt_count=1.
- Backpressure: pkt_len=3, seed=0, tready low for 3 cycles on beat 1.
  - tdata=1 and tvalid=1 held stable through the stall.
  - Sequence 0,1,2 with no loss or duplication.
- Gap insertion: pkt_len=3, gap=2, tready=1.
  - Waveform on tvalid: 1,0,0,1,0,0,1; tdata 0,1,2; tlast on beat 2 only.
- Boundaries and wrap:
  - pkt_len=1, seed=32'hFFFF_FFFF: single beat with tlast=1.
  - Then pkt_len=2, seed=32'hFFFF_FFFF: tdata FFFF_FFFF then 0000_0000.
  - pkt_len=0: no tvalid, done pulse, pkt_count unchanged.
- Start during activity:
  - Pulse start mid-packet and again during DONE: both are ignored, and exactly one packet is emitted.
- Asynchronous reset mid-packet: assert aresetn low between clock edges during beat 2 of 5.
  - tvalid, tlast, busy, state drop to 0 before the next edge; pkt_count=0.
  - A fresh start then works normally.
